// File: rtl/frame_stream_joiner.sv
// Joins three pixel streams (current, previous, background) beat-by-beat into one wide stream,
// discarding beats until all three streams agree on start-of-frame and flagging any loss of alignment.
module frame_stream_joiner #(
    parameter int unsigned TDATA_WIDTH = 24,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                       aclk,
    input  logic                       areset,

    input  logic [TDATA_WIDTH-1:0]     cur_tdata,
    input  logic                       cur_tuser,
    input  logic                       cur_tlast,
    input  logic                       cur_tvalid,
    output logic                       cur_tready,

    input  logic [TDATA_WIDTH-1:0]     prev_tdata,
    input  logic                       prev_tuser,
    input  logic                       prev_tlast,
    input  logic                       prev_tvalid,
    output logic                       prev_tready,

    input  logic [TDATA_WIDTH-1:0]     bg_tdata,
    input  logic                       bg_tuser,
    input  logic                       bg_tlast,
    input  logic                       bg_tvalid,
    output logic                       bg_tready,

    output logic [3*TDATA_WIDTH-1:0]   output_frames_tdata,
    output logic                       output_frames_tuser,
    output logic                       output_frames_tlast,
    output logic                       output_frames_tvalid,
    input  logic                       output_frames_tready,

    input  logic                       err_clear,
    output logic                       sync_error,
    output logic [7:0]                 err_count
);

    localparam int unsigned NS = 3;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic                   user;
        logic                   last;
        logic [TDATA_WIDTH-1:0] data;
    } beat_t;

    typedef enum logic {SYNC, RUN} state_t;

    state_t          state, state_nxt;
    beat_t           in_beat [NS];
    beat_t           head    [NS];
    logic [NS-1:0]   in_valid, in_ready, push, pop, empty, full;
    logic            load, mismatch, all_present, all_sof, heads_match, out_free;

    assign in_beat[0] = {cur_tuser,  cur_tlast,  cur_tdata};
    assign in_beat[1] = {prev_tuser, prev_tlast, prev_tdata};
    assign in_beat[2] = {bg_tuser,   bg_tlast,   bg_tdata};
    assign in_valid   = {bg_tvalid, prev_tvalid, cur_tvalid};

    assign cur_tready  = in_ready[0];
    assign prev_tready = in_ready[1];
    assign bg_tready   = in_ready[2];

    // One first-word-fall-through FIFO per input stream
    for (genvar i = 0; i < NS; i++) begin : g_fifo
        beat_t          mem [FIFO_DEPTH];
        logic [AW:0]    wr_ptr, rd_ptr;

        assign empty[i]    = (wr_ptr == rd_ptr);
        assign full[i]     = (wr_ptr == (rd_ptr ^ PW'(FIFO_DEPTH)));
        assign head[i]     = mem[rd_ptr[AW-1:0]];
        assign in_ready[i] = !full[i] && !areset;
        assign push[i]     = in_valid[i] && in_ready[i];

        always_ff @(posedge aclk) begin
            if (areset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push[i]) wr_ptr <= wr_ptr + PW'(1);
                if (pop[i])  rd_ptr <= rd_ptr + PW'(1);
            end
        end

        always_ff @(posedge aclk) begin
            if (push[i]) mem[wr_ptr[AW-1:0]] <= in_beat[i];
        end
    end

    assign all_present = ~|empty;
    assign all_sof     = all_present && head[0].user && head[1].user && head[2].user;
    assign heads_match = (head[0].user == head[1].user) && (head[0].user == head[2].user) &&
                         (head[0].last == head[1].last) && (head[0].last == head[2].last);
    assign out_free    = !output_frames_tvalid || output_frames_tready;

    always_ff @(posedge aclk) begin
        if (areset) state <= SYNC;
        else        state <= state_nxt;
    end

    // SYNC drops non-SOF heads until all three streams present SOF; RUN joins aligned beats
    always_comb begin
        state_nxt = state;
        pop       = '0;
        load      = 1'b0;
        mismatch  = 1'b0;
        case (state)
            SYNC: begin
                for (int unsigned i = 0; i < NS; i++) begin
                    if (!empty[i] && !head[i].user) pop[i] = 1'b1;
                end
                if (all_sof) state_nxt = RUN;
            end
            RUN: begin
                if (all_present && out_free) begin
                    pop = '1;
                    if (heads_match) begin
                        load = 1'b1;
                    end else begin
                        mismatch  = 1'b1;
                        state_nxt = SYNC;
                    end
                end
            end
            default: state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            output_frames_tvalid <= 1'b0;
            output_frames_tuser  <= 1'b0;
            output_frames_tlast  <= 1'b0;
            output_frames_tdata  <= '0;
        end else if (load) begin
            output_frames_tvalid <= 1'b1;
            output_frames_tuser  <= head[0].user;
            output_frames_tlast  <= head[0].last;
            output_frames_tdata  <= {head[2].data, head[1].data, head[0].data};
        end else if (output_frames_tready) begin
            output_frames_tvalid <= 1'b0;
        end
    end

    // Clear takes priority over a coincident misalignment
    always_ff @(posedge aclk) begin
        if (areset || err_clear) begin
            sync_error <= 1'b0;
            err_count  <= 8'd0;
        end else if (mismatch) begin
            sync_error <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_frame_stream_joiner.sv
// Directed bench for frame_stream_joiner: queue-fed stream drivers, output scoreboard, and status checks.
module tb_frame_stream_joiner;

    localparam int unsigned TW = 24;

    logic            aclk, areset;
    logic [TW-1:0]   cur_tdata, prev_tdata, bg_tdata;
    logic            cur_tuser, cur_tlast, cur_tvalid, cur_tready;
    logic            prev_tuser, prev_tlast, prev_tvalid, prev_tready;
    logic            bg_tuser, bg_tlast, bg_tvalid, bg_tready;
    logic [3*TW-1:0] output_frames_tdata;
    logic            output_frames_tuser, output_frames_tlast, output_frames_tvalid, output_frames_tready;
    logic            err_clear, sync_error;
    logic [7:0]      err_count;

    int              total = 0;
    int              bad   = 0;
    int              n_out = 0;
    bit              hs_c, hs_p, hs_b;
    logic [25:0]     cur_q[$], prev_q[$], bg_q[$];
    logic [73:0]     exp_q[$];

    frame_stream_joiner #(.TDATA_WIDTH(TW), .FIFO_DEPTH(4)) dut (
        .aclk(aclk), .areset(areset),
        .cur_tdata(cur_tdata), .cur_tuser(cur_tuser), .cur_tlast(cur_tlast),
        .cur_tvalid(cur_tvalid), .cur_tready(cur_tready),
        .prev_tdata(prev_tdata), .prev_tuser(prev_tuser), .prev_tlast(prev_tlast),
        .prev_tvalid(prev_tvalid), .prev_tready(prev_tready),
        .bg_tdata(bg_tdata), .bg_tuser(bg_tuser), .bg_tlast(bg_tlast),
        .bg_tvalid(bg_tvalid), .bg_tready(bg_tready),
        .output_frames_tdata(output_frames_tdata), .output_frames_tuser(output_frames_tuser),
        .output_frames_tlast(output_frames_tlast), .output_frames_tvalid(output_frames_tvalid),
        .output_frames_tready(output_frames_tready),
        .err_clear(err_clear), .sync_error(sync_error), .err_count(err_count)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #500000;
        $error("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge aclk);
        #2;
    endtask

    task automatic push_src(input logic [7:0] base, input bit early, input int junk);
        for (int j = 0; j < junk; j++) cur_q.push_back({2'b00, 24'hEE0000 | 24'(j)});
        for (int k = 0; k < 8; k++) begin
            logic [23:0] v;
            v = 24'(base) + 24'(k);
            cur_q.push_back({k == 0, k % 4 == 3, v});
            prev_q.push_back({k == 0, early ? (k == 2 || k == 7) : (k % 4 == 3), v << 8});
            bg_q.push_back({k == 0, k % 4 == 3, v << 16});
        end
    endtask

    task automatic push_exp(input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            logic [23:0] v;
            v = 24'(base) + 24'(k);
            exp_q.push_back({k == 0, k % 4 == 3, v << 16, v << 8, v});
        end
    endtask

    task automatic wait_drain(input int max);
        int c = 0;
        while ((cur_q.size() > 0 || prev_q.size() > 0 || bg_q.size() > 0 || exp_q.size() > 0) && c < max) begin
            step(1);
            c++;
        end
        total++;
        assert (c < max) else begin
            bad++;
            $error("FAIL drain_timeout observed=%0d expected<%0d", c, max);
        end
        step(8);
    endtask

    task automatic wait_outs(input int target, input int max);
        int c = 0;
        while (n_out < target && c < max) begin
            step(1);
            c++;
        end
        total++;
        assert (c < max) else begin
            bad++;
            $error("FAIL out_timeout observed=%0d expected=%0d", n_out, target);
        end
    endtask

    // Stream sources: handshake sampled mid-cycle, next beat presented just after the edge
    initial begin
        cur_tvalid = 1'b0; prev_tvalid = 1'b0; bg_tvalid = 1'b0;
        cur_tdata = '0; prev_tdata = '0; bg_tdata = '0;
        cur_tuser = 1'b0; prev_tuser = 1'b0; bg_tuser = 1'b0;
        cur_tlast = 1'b0; prev_tlast = 1'b0; bg_tlast = 1'b0;
        forever begin
            @(negedge aclk);
            hs_c = cur_tvalid && cur_tready;
            hs_p = prev_tvalid && prev_tready;
            hs_b = bg_tvalid && bg_tready;
            @(posedge aclk);
            #1;
            if (hs_c && cur_q.size() > 0) void'(cur_q.pop_front());
            if (hs_p && prev_q.size() > 0) void'(prev_q.pop_front());
            if (hs_b && bg_q.size() > 0) void'(bg_q.pop_front());
            cur_tvalid  = cur_q.size() > 0;
            prev_tvalid = prev_q.size() > 0;
            bg_tvalid   = bg_q.size() > 0;
            if (cur_tvalid)  {cur_tuser, cur_tlast, cur_tdata}    = cur_q[0];
            if (prev_tvalid) {prev_tuser, prev_tlast, prev_tdata} = prev_q[0];
            if (bg_tvalid)   {bg_tuser, bg_tlast, bg_tdata}       = bg_q[0];
        end
    end

    // Output scoreboard
    initial begin
        forever begin
            @(negedge aclk);
            if (output_frames_tvalid && output_frames_tready && !areset) begin
                n_out++;
                total++;
                assert (exp_q.size() > 0) else begin
                    bad++;
                    $error("FAIL out_unexpected observed=%0h expected=none", output_frames_tdata);
                end
                if (exp_q.size() > 0)
                    check("out_beat", {6'b0, output_frames_tuser, output_frames_tlast, output_frames_tdata},
                          {6'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int n0;
        areset = 1'b1;
        err_clear = 1'b0;
        output_frames_tready = 1'b1;
        step(2);
        check("rst_tvalid", 80'(output_frames_tvalid), 80'(0));
        check("rst_tuser", 80'(output_frames_tuser), 80'(0));
        check("rst_tlast", 80'(output_frames_tlast), 80'(0));
        check("rst_tdata", 80'(output_frames_tdata), 80'(0));
        check("rst_sync_error", 80'(sync_error), 80'(0));
        check("rst_err_count", 80'(err_count), 80'(0));
        check("rst_ready", 80'({cur_tready, prev_tready, bg_tready}), 80'(0));
        areset = 1'b0;

        // aligned frame
        push_src(8'h01, 1'b0, 0);
        push_exp(8'h01, 8);
        wait_drain(200);
        check("aligned_sync_error", 80'(sync_error), 80'(0));

        // latency and full throughput while in RUN
        push_src(8'h11, 1'b0, 0);
        push_exp(8'h11, 8);
        step(2);
        check("lat_before", 80'(output_frames_tvalid), 80'(0));
        step(1);
        check("lat_after", 80'(output_frames_tvalid), 80'(1));
        step(8);
        check("throughput", 80'(exp_q.size()), 80'(0));
        wait_drain(200);

        // skewed start after a reset
        areset = 1'b1;
        step(1);
        areset = 1'b0;
        push_src(8'h21, 1'b0, 3);
        push_exp(8'h21, 8);
        wait_drain(200);
        check("skew_err_count", 80'(err_count), 80'(0));

        // backpressure
        n0 = n_out;
        push_src(8'h31, 1'b0, 0);
        push_src(8'h41, 1'b0, 0);
        push_exp(8'h31, 8);
        push_exp(8'h41, 8);
        wait_outs(n0 + 3, 100);
        output_frames_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("bp_hold", {5'b0, output_frames_tvalid, output_frames_tuser, output_frames_tlast, output_frames_tdata},
                  {5'b0, 1'b1, exp_q[0]});
        end
        check("bp_ready", 80'({cur_tready, prev_tready, bg_tready}), 80'(0));
        output_frames_tready = 1'b1;
        wait_drain(300);

        // misalignment: prev tlast one beat early
        push_src(8'h51, 1'b1, 0);
        push_src(8'h61, 1'b0, 0);
        push_exp(8'h51, 2);
        push_exp(8'h61, 8);
        wait_drain(300);
        check("mis_sync_error", 80'(sync_error), 80'(1));
        check("mis_err_count", 80'(err_count), 80'(1));
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
        check("clr_sync_error", 80'(sync_error), 80'(0));
        check("clr_err_count", 80'(err_count), 80'(0));

        // reset mid-frame
        n0 = n_out;
        push_src(8'h71, 1'b0, 0);
        push_src(8'h81, 1'b0, 0);
        push_exp(8'h71, 8);
        wait_outs(n0 + 3, 100);
        areset = 1'b1;
        exp_q.delete();
        step(1);
        check("midrst_tvalid", 80'(output_frames_tvalid), 80'(0));
        check("midrst_tdata", 80'(output_frames_tdata), 80'(0));
        check("midrst_ready", 80'({cur_tready, prev_tready, bg_tready}), 80'(0));
        areset = 1'b0;
        push_exp(8'h81, 8);
        wait_drain(300);

        // saturation
        for (int i = 0; i < 300; i++) begin
            cur_q.push_back({2'b10, 24'(i)});
            prev_q.push_back({2'b11, 24'(i) << 8});
            bg_q.push_back({2'b10, 24'(i) << 16});
        end
        wait_drain(4000);
        check("sat_err_count", 80'(err_count), 80'(255));
        check("sat_sync_error", 80'(sync_error), 80'(1));

        // clear held across further mismatches
        err_clear = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cur_q.push_back({2'b10, 24'(i)});
            prev_q.push_back({2'b11, 24'(i)});
            bg_q.push_back({2'b10, 24'(i)});
        end
        wait_drain(200);
        err_clear = 1'b0;
        step(1);
        check("clr_win_count", 80'(err_count), 80'(0));
        check("clr_win_sync", 80'(sync_error), 80'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_stream_joiner.md
FRAME_STREAM_JOINER -- requirements
Module: frame_stream_joiner

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 24, bits per pixel per stream.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, power of two >= 2, entries per input FIFO.
REQ-003 SHALL have port aclk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port areset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports cur_tdata/cur_tuser/cur_tlast/cur_tvalid  input  TDATA_WIDTH/1/1/1  current-frame AXI-Stream slave.
REQ-006 SHALL have port cur_tready  output  1  current-frame ready.
REQ-007 SHALL have prev_* and bg_* port sets identical to REQ-005/006, for previous-frame and background streams.
REQ-008 SHALL have ports output_frames_tdata/tuser/tlast/tvalid  output  3*TDATA_WIDTH/1/1/1  joined master stream.
REQ-009 SHALL have port output_frames_tready  input  1  downstream ready.
REQ-010 SHALL have port err_clear  input  1  clears sync_error and err_count.
REQ-011 SHALL have ports sync_error  output  1  sticky misalignment flag; err_count  output  8  saturating misalignment count.

Function
REQ-012 Each input SHALL feed its own first-word-fall-through FIFO of FIFO_DEPTH entries storing {tuser, tlast, tdata}; x_tready = FIFO not full and not areset.
REQ-013 Input beat accepted on edge where tvalid & tready; simultaneous push and pop on a full FIFO SHALL NOT be accepted (tready already low); on non-full FIFO, push and pop in the same cycle SHALL both occur, level unchanged.
REQ-014 FSM SHALL have two states, SYNC and RUN.
REQ-015 SYNC: each FIFO whose head is present with tuser=0 SHALL pop (discard) that head each cycle; when all three heads present with tuser=1, SHALL go to RUN with no pop.
REQ-016 RUN: join SHALL fire when all three FIFOs non-empty and output register empty or output_frames_tready=1.
REQ-017 On join with tuser and tlast equal across all three heads: pop all three, load output register with tdata = {bg, prev, cur} (cur in bits TDATA_WIDTH-1:0, bg in top bits), tuser/tlast from cur head, tvalid=1.
REQ-018 On join with any tuser or tlast mismatch: pop all three, do not load output, set sync_error, increment err_count (saturate at 255), go to SYNC.
REQ-019 Output register SHALL hold tdata/tuser/tlast stable while tvalid=1 and tready=0; tvalid clears after handshake unless reloaded the same cycle.
REQ-020 Latency: input handshake on edge N into empty pipeline with ready downstream -> output_frames_tvalid=1 after edge N+1; full throughput of one beat per cycle in RUN.
REQ-021 err_clear SHALL zero sync_error and err_count on the next edge; if a mismatch coincides, err_clear wins and the count becomes 0.
REQ-022 No beat SHALL be dropped or duplicated in RUN; only SYNC discard and REQ-018 remove beats.

Reset
REQ-023 While areset=1 at an edge: all FIFOs emptied, FSM=SYNC, output_frames_tvalid/tuser/tlast=0, output_frames_tdata=0, sync_error=0, err_count=0, all x_tready=0.
REQ-024 Reset mid-frame SHALL discard all buffered and registered beats; after release the block resynchronises on the next tuser=1 on all three streams.

Verification
REQ-025 Aligned frames: three streams, 4x2 frame, cur=0x000001.., prev=0x000100.., bg=0x010000.. -> 8 output beats, tdata={bg,prev,cur}, tuser on beat 0, tlast on beats 3 and 7, sync_error=0.
REQ-026 Skewed start: cur has 3 junk beats (tuser=0) before SOF, others none -> junk discarded, first output beat has tuser=1 and cur SOF pixel, err_count=0.
REQ-027 Backpressure: output_frames_tready=0 for 10 cycles mid-frame -> tdata held stable, all x_tready fall after FIFOs fill (FIFO_DEPTH beats each), no loss after release.
REQ-028 Misalignment: prev tlast one beat early -> sync_error=1, err_count=1, block returns to SYNC and resumes clean output at next common SOF; err_clear then zeroes both.
REQ-029 Reset mid-frame: areset pulsed 1 cycle after 3 beats joined -> output_frames_tvalid=0 next cycle, FIFOs empty, next output beat is next SOF.
REQ-030 Saturation: 300 forced mismatches -> err_count=255.
